// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and branch-flush controller for the 5-stage pipeline, with a
// counter FSM that holds the front end during multi-cycle EX ops. Optional perf counters: HAZ_PERF_CNT_EN.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 3,
    parameter int MUL_LAT      = 4,
    parameter int R0_HARDWIRED = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              br_taken,
    input  logic [REG_AW-1:0] ex_rs1,
    input  logic [REG_AW-1:0] ex_rs2,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_memread,
    input  logic              ex_mc_start,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwr,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwr,
    output logic              pc_stall,
    output logic              ifid_stall,
    output logic              ifid_flush,
    output logic              idex_bubble,
    output logic              idex_hold,
    output logic              exmem_bubble,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic              mc_busy,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    typedef enum logic {IDLE, BUSY} state_t;

    // The start cycle and the completion cycle are both part of the occupancy.
    localparam logic [7:0] MC_INIT = 8'((MUL_LAT > 1) ? MUL_LAT - 2 : 0);

    state_t     state, state_next;
    logic [7:0] cnt, cnt_next;
    logic       mc_hold;
    logic       load_use;

    function automatic logic reg_match(input logic en, input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs);
        return en && (rd == rs) && !((R0_HARDWIRED != 0) && (rd == '0));
    endfunction

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        mc_hold    = 1'b0;
        case (state)
            IDLE: begin
                if (ex_mc_start && (MUL_LAT > 1)) begin
                    mc_hold    = 1'b1;
                    cnt_next   = MC_INIT;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (cnt != 8'd0) begin
                    mc_hold  = 1'b1;
                    cnt_next = cnt - 8'd1;
                end else begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 8'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    assign load_use = reg_match(ex_memread && id_use_rs1, ex_rd, id_rs1) ||
                      reg_match(ex_memread && id_use_rs2, ex_rd, id_rs2);

    always_comb begin
        pc_stall     = 1'b0;
        ifid_stall   = 1'b0;
        ifid_flush   = 1'b0;
        idex_bubble  = 1'b0;
        idex_hold    = 1'b0;
        exmem_bubble = 1'b0;
        fwd_a_sel    = 2'b00;
        fwd_b_sel    = 2'b00;
        mc_busy      = 1'b0;
        if (rst_n) begin
            mc_busy = (state == BUSY);
            if (reg_match(mem_regwr, mem_rd, ex_rs1))     fwd_a_sel = 2'b10;
            else if (reg_match(wb_regwr, wb_rd, ex_rs1))  fwd_a_sel = 2'b01;
            if (reg_match(mem_regwr, mem_rd, ex_rs2))     fwd_b_sel = 2'b10;
            else if (reg_match(wb_regwr, wb_rd, ex_rs2))  fwd_b_sel = 2'b01;
            // Priority: multi-cycle hold, then load-use, then branch flush.
            if (mc_hold) begin
                pc_stall     = 1'b1;
                ifid_stall   = 1'b1;
                idex_hold    = 1'b1;
                exmem_bubble = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_bubble = 1'b1;
            end else if (br_taken) begin
                ifid_flush = 1'b1;
            end
        end
    end

`ifdef HAZ_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q, flush_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (pc_stall && (stall_q != '1)) stall_q <= stall_q + CNT_W'(1);
            if (ifid_flush && (flush_q != '1)) flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench: instance a uses defaults (MUL_LAT=4, R0 hardwired, CNT_W=16);
// instance b uses MUL_LAT=1, R0_HARDWIRED=0, CNT_W=2 and shares the same stimulus.
module tb_pipe_hazard_ctrl;

    localparam int AW = 3;

`ifdef HAZ_PERF_CNT_EN
    localparam int PERF_ON = 1;
`else
    localparam int PERF_ON = 0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [AW-1:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic id_use_rs1, id_use_rs2, br_taken, ex_memread, ex_mc_start, mem_regwr, wb_regwr;

    logic a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_bubble, a_idex_hold, a_exmem_bubble, a_mc_busy;
    logic [1:0] a_fwd_a_sel, a_fwd_b_sel;
    logic [15:0] a_stall_cnt, a_flush_cnt;
    logic b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_bubble, b_idex_hold, b_exmem_bubble, b_mc_busy;
    logic [1:0] b_fwd_a_sel, b_fwd_b_sel;
    logic [1:0] b_stall_cnt, b_flush_cnt;

    // Control vector order: pc_stall ifid_stall ifid_flush idex_bubble idex_hold exmem_bubble mc_busy
    logic [6:0] a_ctl, b_ctl;
    assign a_ctl = {a_pc_stall, a_ifid_stall, a_ifid_flush, a_idex_bubble, a_idex_hold, a_exmem_bubble, a_mc_busy};
    assign b_ctl = {b_pc_stall, b_ifid_stall, b_ifid_flush, b_idex_bubble, b_idex_hold, b_exmem_bubble, b_mc_busy};

    localparam logic [6:0] CTL_NONE  = 7'b0000000;
    localparam logic [6:0] CTL_LU    = 7'b1101000;
    localparam logic [6:0] CTL_FLUSH = 7'b0010000;
    localparam logic [6:0] CTL_HOLD0 = 7'b1100110;
    localparam logic [6:0] CTL_HOLDB = 7'b1100111;

    int checks = 0;
    int errors = 0;

    pipe_hazard_ctrl #(.REG_AW(AW), .MUL_LAT(4), .R0_HARDWIRED(1), .CNT_W(16)) u_a (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .br_taken(br_taken),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_mc_start(ex_mc_start), .mem_rd(mem_rd), .mem_regwr(mem_regwr),
        .wb_rd(wb_rd), .wb_regwr(wb_regwr), .pc_stall(a_pc_stall), .ifid_stall(a_ifid_stall),
        .ifid_flush(a_ifid_flush), .idex_bubble(a_idex_bubble), .idex_hold(a_idex_hold),
        .exmem_bubble(a_exmem_bubble), .fwd_a_sel(a_fwd_a_sel), .fwd_b_sel(a_fwd_b_sel),
        .mc_busy(a_mc_busy), .stall_cnt(a_stall_cnt), .flush_cnt(a_flush_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(AW), .MUL_LAT(1), .R0_HARDWIRED(0), .CNT_W(2)) u_b (
        .clk(clk), .rst_n(rst_n), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .br_taken(br_taken),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_memread(ex_memread),
        .ex_mc_start(ex_mc_start), .mem_rd(mem_rd), .mem_regwr(mem_regwr),
        .wb_rd(wb_rd), .wb_regwr(wb_regwr), .pc_stall(b_pc_stall), .ifid_stall(b_ifid_stall),
        .ifid_flush(b_ifid_flush), .idex_bubble(b_idex_bubble), .idex_hold(b_idex_hold),
        .exmem_bubble(b_exmem_bubble), .fwd_a_sel(b_fwd_a_sel), .fwd_b_sel(b_fwd_b_sel),
        .mc_busy(b_mc_busy), .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt)
    );

    task automatic idle_inputs();
        id_rs1 = 3'd1; id_rs2 = 3'd1; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; br_taken = 1'b0;
        ex_rs1 = 3'd6; ex_rs2 = 3'd6; ex_rd = 3'd7; ex_memread = 1'b0; ex_mc_start = 1'b0;
        mem_rd = 3'd5; mem_regwr = 1'b0; wb_rd = 3'd5; wb_regwr = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic set_load_use();
        idle_inputs();
        ex_memread = 1'b1; ex_rd = 3'd2; id_rs1 = 3'd2; id_use_rs1 = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_load_use();
        br_taken = 1'b1; ex_mc_start = 1'b1; mem_regwr = 1'b1; mem_rd = 3'd6;
        settle();
        checks++; if (a_ctl !== CTL_NONE) begin errors++; $display("FAIL rst_ctl_a got %b exp %b", a_ctl, CTL_NONE); end
        checks++; if (b_ctl !== CTL_NONE) begin errors++; $display("FAIL rst_ctl_b got %b exp %b", b_ctl, CTL_NONE); end
        checks++; if (a_fwd_a_sel !== 2'b00) begin errors++; $display("FAIL rst_fwd_a got %b exp 00", a_fwd_a_sel); end
        advance();
        settle();
        checks++; if (a_stall_cnt !== 16'd0 || a_flush_cnt !== 16'd0) begin
            errors++; $display("FAIL rst_cnt got %0d/%0d exp 0/0", a_stall_cnt, a_flush_cnt); end
        advance();
        rst_n = 1'b1;
        idle_inputs();
        settle();
        checks++; if (a_ctl !== CTL_NONE) begin errors++; $display("FAIL post_rst_ctl got %b exp %b", a_ctl, CTL_NONE); end
        advance();
    endtask

    task automatic test_forward();
        idle_inputs();
        mem_regwr = 1'b1; mem_rd = 3'd3; wb_regwr = 1'b1; wb_rd = 3'd3; ex_rs1 = 3'd3; ex_rs2 = 3'd4;
        settle();
        checks++; if (a_fwd_a_sel !== 2'b10) begin errors++; $display("FAIL fwd_prio got %b exp 10", a_fwd_a_sel); end
        checks++; if (a_fwd_b_sel !== 2'b00) begin errors++; $display("FAIL fwd_b_none got %b exp 00", a_fwd_b_sel); end
        mem_regwr = 1'b0;
        #1;
        checks++; if (a_fwd_a_sel !== 2'b01) begin errors++; $display("FAIL fwd_wb got %b exp 01", a_fwd_a_sel); end
        wb_regwr = 1'b0;
        #1;
        checks++; if (a_fwd_a_sel !== 2'b00) begin errors++; $display("FAIL fwd_rf got %b exp 00", a_fwd_a_sel); end
        wb_regwr = 1'b1; wb_rd = 3'd4; mem_regwr = 1'b1; mem_rd = 3'd3;
        #1;
        checks++; if ({a_fwd_a_sel, a_fwd_b_sel} !== 4'b1001) begin
            errors++; $display("FAIL fwd_split got %b exp 1001", {a_fwd_a_sel, a_fwd_b_sel}); end
        advance();
    endtask

    task automatic test_r0();
        idle_inputs();
        mem_regwr = 1'b1; mem_rd = 3'd0; ex_rs2 = 3'd0;
        settle();
        checks++; if (a_fwd_b_sel !== 2'b00) begin errors++; $display("FAIL r0_hw_mem got %b exp 00", a_fwd_b_sel); end
        checks++; if (b_fwd_b_sel !== 2'b10) begin errors++; $display("FAIL r0_soft_mem got %b exp 10", b_fwd_b_sel); end
        mem_regwr = 1'b0; wb_regwr = 1'b1; wb_rd = 3'd0;
        #1;
        checks++; if (a_fwd_b_sel !== 2'b00) begin errors++; $display("FAIL r0_hw_wb got %b exp 00", a_fwd_b_sel); end
        checks++; if (b_fwd_b_sel !== 2'b01) begin errors++; $display("FAIL r0_soft_wb got %b exp 01", b_fwd_b_sel); end
        advance();
    endtask

    task automatic test_load_use();
        set_load_use();
        br_taken = 1'b1;
        settle();
        checks++; if (a_ctl !== CTL_LU) begin errors++; $display("FAIL lu_stall got %b exp %b", a_ctl, CTL_LU); end
        advance();
        idle_inputs();
        br_taken = 1'b1;
        settle();
        checks++; if (a_ctl !== CTL_FLUSH) begin errors++; $display("FAIL lu_then_flush got %b exp %b", a_ctl, CTL_FLUSH); end
        advance();
        set_load_use();
        id_use_rs1 = 1'b0; id_rs2 = 3'd2;
        settle();
        checks++; if (a_ctl !== CTL_NONE) begin errors++; $display("FAIL lu_unused got %b exp %b", a_ctl, CTL_NONE); end
        advance();
        set_load_use();
        id_use_rs1 = 1'b0; id_rs1 = 3'd5; id_rs2 = 3'd2; id_use_rs2 = 1'b1;
        settle();
        checks++; if (a_ctl !== CTL_LU) begin errors++; $display("FAIL lu_rs2 got %b exp %b", a_ctl, CTL_LU); end
        advance();
        set_load_use();
        id_use_rs1 = 1'b0; ex_rd = 3'd0; id_rs2 = 3'd0; id_use_rs2 = 1'b1;
        settle();
        checks++; if (a_ctl !== CTL_NONE) begin errors++; $display("FAIL lu_r0_hw got %b exp %b", a_ctl, CTL_NONE); end
        checks++; if (b_ctl !== CTL_LU) begin errors++; $display("FAIL lu_r0_soft got %b exp %b", b_ctl, CTL_LU); end
        advance();
    endtask

    task automatic test_multicycle();
        set_load_use();
        ex_mc_start = 1'b1;
        settle();
        checks++; if (a_ctl !== CTL_HOLD0) begin errors++; $display("FAIL mc_c0 got %b exp %b", a_ctl, CTL_HOLD0); end
        checks++; if (b_ctl !== CTL_LU) begin errors++; $display("FAIL mc_lat1 got %b exp %b", b_ctl, CTL_LU); end
        advance();
        idle_inputs();
        ex_mc_start = 1'b1; br_taken = 1'b1; mem_regwr = 1'b1; mem_rd = 3'd4; ex_rs2 = 3'd4;
        settle();
        checks++; if (a_ctl !== CTL_HOLDB) begin errors++; $display("FAIL mc_c1 got %b exp %b", a_ctl, CTL_HOLDB); end
        checks++; if (a_fwd_b_sel !== 2'b10) begin errors++; $display("FAIL mc_fwd got %b exp 10", a_fwd_b_sel); end
        advance();
        idle_inputs();
        settle();
        checks++; if (a_ctl !== CTL_HOLDB) begin errors++; $display("FAIL mc_c2 got %b exp %b", a_ctl, CTL_HOLDB); end
        advance();
        br_taken = 1'b1;
        settle();
        checks++; if (a_ctl !== 7'b0010001) begin errors++; $display("FAIL mc_c3 got %b exp 0010001", a_ctl); end
        advance();
        idle_inputs();
        settle();
        checks++; if (a_ctl !== CTL_NONE) begin errors++; $display("FAIL mc_c4 got %b exp %b", a_ctl, CTL_NONE); end
        advance();
    endtask

    task automatic test_reset_mid_op();
        idle_inputs();
        ex_mc_start = 1'b1;
        settle();
        checks++; if (a_ctl !== CTL_HOLD0) begin errors++; $display("FAIL rmo_start got %b exp %b", a_ctl, CTL_HOLD0); end
        advance();
        rst_n = 1'b0;
        ex_mc_start = 1'b0; br_taken = 1'b1; mem_regwr = 1'b1; mem_rd = 3'd6;
        settle();
        checks++; if (a_ctl !== CTL_NONE || a_fwd_a_sel !== 2'b00) begin
            errors++; $display("FAIL rmo_low got %b/%b exp %b/00", a_ctl, a_fwd_a_sel, CTL_NONE); end
        advance();
        settle();
        checks++; if (a_ctl !== CTL_NONE) begin errors++; $display("FAIL rmo_low2 got %b exp %b", a_ctl, CTL_NONE); end
        advance();
        rst_n = 1'b1;
        idle_inputs();
        settle();
        checks++; if (a_ctl !== CTL_NONE) begin errors++; $display("FAIL rmo_idle got %b exp %b", a_ctl, CTL_NONE); end
        advance();
        ex_mc_start = 1'b1;
        settle();
        checks++; if (a_ctl !== CTL_HOLD0) begin errors++; $display("FAIL rmo_restart got %b exp %b", a_ctl, CTL_HOLD0); end
        advance();
        idle_inputs();
        for (int i = 0; i < 4; i++) advance();
    endtask

    task automatic test_perf();
        rst_n = 1'b0;
        idle_inputs();
        advance();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_load_use();
            advance();
        end
        for (int i = 0; i < 2; i++) begin
            idle_inputs();
            br_taken = 1'b1;
            advance();
        end
        idle_inputs();
        settle();
        checks++; if (a_stall_cnt !== 16'(3 * PERF_ON) || a_flush_cnt !== 16'(2 * PERF_ON)) begin
            errors++; $display("FAIL perf_a got %0d/%0d exp %0d/%0d", a_stall_cnt, a_flush_cnt, 3 * PERF_ON, 2 * PERF_ON); end
        checks++; if (b_stall_cnt !== 2'(3 * PERF_ON) || b_flush_cnt !== 2'(2 * PERF_ON)) begin
            errors++; $display("FAIL perf_b got %0d/%0d exp %0d/%0d", b_stall_cnt, b_flush_cnt, 3 * PERF_ON, 2 * PERF_ON); end
        advance();
        for (int i = 0; i < 2; i++) begin
            set_load_use();
            advance();
        end
        idle_inputs();
        settle();
        checks++; if (a_stall_cnt !== 16'(5 * PERF_ON)) begin
            errors++; $display("FAIL perf_a5 got %0d exp %0d", a_stall_cnt, 5 * PERF_ON); end
        checks++; if (b_stall_cnt !== 2'(3 * PERF_ON)) begin
            errors++; $display("FAIL perf_sat got %0d exp %0d", b_stall_cnt, 3 * PERF_ON); end
        advance();
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        test_reset();
        test_forward();
        test_r0();
        test_load_use();
        test_multicycle();
        test_reset_mid_op();
        test_perf();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Parametrised hazard and forwarding controller for the 5-stage pipeline.
- Merges load-use detection, EX-operand forwarding and branch-flush control into one block.
- Adds support for multi-cycle EX operations: a counter FSM holds IF/ID/EX and inserts bubbles into EX/MEM until the operation completes.
- Sits beside the ID/EX register. Drives the PC write-enable, the IF/ID hold/flush, the ID/EX control-zero mux and the ALU operand mux selects.

Parameters:
- REG_AW, 3: register address width.
- MUL_LAT, 4: total EX occupancy in cycles of a multi-cycle op; legal range 1..255.
- R0_HARDWIRED, 1: when 1, register 0 never creates a hazard or a forward.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- id_rs1, id_rs2  in  REG_AW  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1 / rs2
- br_taken  in  1  branch/jump resolved taken in ID
- ex_rs1, ex_rs2  in  REG_AW  source registers of the instruction in EX
- ex_rd  in  REG_AW  destination register of the instruction in EX
- ex_memread  in  1  EX instruction is a load
- ex_mc_start  in  1  multi-cycle op entering EX this cycle
- mem_rd  in  REG_AW  EX/MEM destination register
- mem_regwr  in  1  EX/MEM register write enable
- wb_rd  in  REG_AW  MEM/WB destination register
- wb_regwr  in  1  MEM/WB register write enable
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  zero IF/ID
- idex_bubble  out  1  zero ID/EX control fields
- idex_hold  out  1  hold ID/EX contents
- exmem_bubble  out  1  zero EX/MEM control fields
- fwd_a_sel, fwd_b_sel  out  2  ALU operand select: 00 register file, 01 WB data, 10 EX/MEM ALU out
- mc_busy  out  1  FSM is in BUSY
- stall_cnt, flush_cnt  out  CNT_W  performance counters

Behaviour:
- rst_n low at a clock edge: state<=IDLE, cnt<=0, perf counters<=0.
- While rst_n is low, every control output is 0 and the forward selects are 00 (combinational gating).
- All outputs are combinational from the inputs and the current state; zero added latency.
- A register "matches" only when its write enable is 1, the addresses are equal, and NOT (R0_HARDWIRED and rd==0).
- Forwarding, per operand:
  - 10 if EX/MEM matches ex_rsX;
  - else 01 if MEM/WB matches;
  - else 00.
  - EX/MEM has priority over MEM/WB.
- FSM states: IDLE and BUSY, with an 8-bit cnt.
  - IDLE, ex_mc_start=1, MUL_LAT>1: mc_hold=1, cnt<=MUL_LAT-2, go to BUSY.
  - IDLE, ex_mc_start=1, MUL_LAT==1: no effect.
  - BUSY, cnt!=0: mc_hold=1, cnt<=cnt-1.
  - BUSY, cnt==0: mc_hold=0 (completion cycle), go to IDLE.
  - ex_mc_start is ignored while in BUSY.
  - Total EX occupancy is exactly MUL_LAT cycles.
- mc_busy is 1 exactly when state==BUSY.
- When mc_hold=1: pc_stall=ifid_stall=idex_hold=exmem_bubble=1; idex_bubble=0; ifid_flush=0. Load-use and br_taken are suppressed.
- Load-use (when mc_hold=0) fires when all of these hold:
  - ex_memread=1;
  - ex_rd matches (id_use_rs1 and id_rs1) or (id_use_rs2 and id_rs2);
  - the R0 rule applies.
  - Result: pc_stall=ifid_stall=idex_bubble=1 for one cycle, and ifid_flush=0. The branch is re-evaluated next cycle.
- br_taken with no hold and no load-use: ifid_flush=1 for that cycle; all stall outputs 0.
- If ex_memread and ex_mc_start are both asserted, the mc path dominates.
- Forward selects remain valid during holds.

Optional Feature:
- Macro: HAZ_PERF_CNT_EN.
- Defined:
  - stall_cnt increments on every cycle with pc_stall=1.
  - flush_cnt increments on every cycle with ifid_flush=1.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both ports are tied to 0 and no counter flops are built.

Test Plan:
- Forward priority: mem_regwr=1, mem_rd=3, wb_regwr=1, wb_rd=3, ex_rs1=3 -> fwd_a_sel=10. Then drop mem_regwr -> 01. Then drop wb_regwr -> 00.
- R0 rule: R0_HARDWIRED=1, mem_regwr=1, mem_rd=0, ex_rs2=0 -> fwd_b_sel=00. Same stimulus with R0_HARDWIRED=0 -> 10.
- Load-use: ex_memread=1, ex_rd=2, id_rs1=2, id_use_rs1=1, br_taken=1 -> pc_stall=ifid_stall=idex_bubble=1, ifid_flush=0. Next cycle with ex_memread=0 and br_taken=1 -> ifid_flush=1, no stall.
- Multi-cycle: MUL_LAT=4, ex_mc_start pulse at cycle 0 plus a second pulse at cycle 1 -> hold/exmem_bubble=1 in cycles 0-2 and 0 in cycle 3; mc_busy=1 in cycles 1-3; the second pulse is ignored.
- Reset mid-op: rst_n=0 during cycle 1 of a MUL_LAT=4 op -> all outputs 0 while low; after release, state is IDLE, mc_busy=0 and no hold.
- HAZ_PERF_CNT_EN: three load-use stalls plus two flushes -> stall_cnt=3, flush_cnt=2. With CNT_W=2, five stalls -> stall_cnt=3 (saturated).
